// File: rtl/word_uart_pkg.sv
// Shared types and framing constants for the word UART transmitter.
package word_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int FRAME_BITS = 10;
    localparam int WORD_BYTES = 2;

endpackage

// File: rtl/word_uart_tx_baud_gen.sv
// Bit-time counter for the UART.
// bit_tick marks the last cycle of a bit; pre_tick marks the cycle just before it.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
        bit_tick = !clear && (cnt_q == CNT_LAST);
        pre_tick = !clear && (cnt_q == CNT_PRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/word_uart_tx.sv
// Sends a 16-bit word as two back-to-back 8N1 frames, low byte first.
// All outputs are registered from next-state values, so tx follows start on the same edge.
module word_uart_tx
    import word_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_BITS - 3);
    localparam logic       LAST_BYTE     = 1'(WORD_BYTES - 1);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic        byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_tick;
    logic        pre_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == IDLE),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hi_byte_d  = hi_byte_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = START;
                    shift_d    = data_in[7:0];
                    hi_byte_d  = data_in[15:8];
                    byte_idx_d = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_DATA_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                // Second frame starts straight out of the first stop bit, no idle gap.
                if (bit_tick) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = IDLE;
                        byte_idx_d = 1'b0;
                    end else begin
                        state_d    = START;
                        byte_idx_d = 1'b1;
                        shift_d    = hi_byte_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (byte_idx_q == LAST_BYTE) && pre_tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            hi_byte_q  <= '0;
            byte_idx_q <= 1'b0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hi_byte_q  <= hi_byte_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_word_uart_tx.sv
// Self-checking bench for word_uart_tx at two baud settings (4 and 2 clocks per bit).
module tb_word_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n4, rst_n2;
    logic        start4, start2;
    logic [15:0] data4, data2;
    logic        tx4, busy4, done4;
    logic        tx2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .start(start4), .data_in(data4),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    word_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .start(start2), .data_in(data2),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of each of the 20 bit slots: start, 8 data LSB first, stop, twice.
    function automatic logic [19:0] frame_bits(input logic [15:0] w);
        logic [19:0] b;
        b[0]  = 1'b0;
        b[9]  = 1'b1;
        b[10] = 1'b0;
        b[19] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b[1 + i]  = w[i];
            b[11 + i] = w[8 + i];
        end
        return b;
    endfunction

    function automatic logic [2:0] obs_vec(input int n);
        return (n == 4) ? {tx4, busy4, done4} : {tx2, busy2, done2};
    endfunction

    task automatic set_start(input int n, input logic v, input logic [15:0] d);
        if (n == 4) begin
            start4 = v;
            data4  = d;
        end else begin
            start2 = v;
            data2  = d;
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            check($sformatf("%s dut4 c=%0d", tag, c), obs_vec(4), 3'b100);
            check($sformatf("%s dut2 c=%0d", tag, c), obs_vec(2), 3'b100);
            @(posedge clk); #1;
        end
    endtask

    // Requests w and checks every cycle of the 20N-cycle transmission plus the first idle cycle.
    task automatic send_word(input int n, input logic [15:0] w, input bit hold,
                             input int guard_t, input string tag);
        logic [19:0] bits;
        bits = frame_bits(w);
        set_start(n, 1'b1, w);
        @(posedge clk); #1;
        for (int t = 0; t < 20 * n; t++) begin
            if (t == guard_t) begin
                set_start(n, 1'b1, 16'h1234);
            end else if (!hold) begin
                set_start(n, 1'b0, 16'($urandom));
            end
            check($sformatf("%s t=%0d", tag, t), obs_vec(n),
                  {bits[t / n], 1'b1, logic'(t == 20 * n - 1)});
            @(posedge clk); #1;
        end
        if (!hold) begin
            set_start(n, 1'b0, 16'h0000);
        end
        check($sformatf("%s end", tag), obs_vec(n), 3'b100);
    endtask

    initial begin
        int          n;
        int          guard;
        logic [15:0] w;

        rst_n4 = 1'b0;
        rst_n2 = 1'b0;
        start4 = 1'b0;
        start2 = 1'b0;
        data4  = 16'h0000;
        data2  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n4 = 1'b1;
        rst_n2 = 1'b1;
        idle_check(50, "reset");

        send_word(4, 16'hA55A, 1'b0, -1, "basic");
        idle_check(3, "post_basic");

        // A request at cycle 20 must be dropped, leaving no second transmission.
        send_word(4, 16'h00FF, 1'b0, 20, "guard");
        idle_check(30, "post_guard");

        set_start(2, 1'b1, 16'h0001);
        send_word(2, 16'h0001, 1'b1, -1, "b2b0");
        send_word(2, 16'h0001, 1'b1, -1, "b2b1");
        send_word(2, 16'h0001, 1'b1, -1, "b2b2");
        set_start(2, 1'b0, 16'h0000);
        idle_check(5, "post_b2b");

        // Reset in the middle of frame 1 bit 3 must clear the outputs without waiting for an edge.
        set_start(4, 1'b1, 16'h3C96);
        @(posedge clk); #1;
        set_start(4, 1'b0, 16'h0000);
        repeat (13 * 4 + 1) @(posedge clk);
        #1;
        check("pre_reset busy", {31'd0, busy4}, 32'd1);
        rst_n4 = 1'b0;
        #1;
        check("async_reset", obs_vec(4), 3'b100);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("in_reset c=%0d", c), obs_vec(4), 3'b100);
        end
        rst_n4 = 1'b1;
        idle_check(2, "post_reset");
        send_word(4, 16'h8000, 1'b0, -1, "after_reset");

        send_word(2, 16'h0000, 1'b0, -1, "zeros");
        send_word(2, 16'hFFFF, 1'b0, -1, "ones");

        // A request landing on the done cycle is ignored.
        send_word(4, 16'($urandom), 1'b0, 79, "start_at_done");
        idle_check(4, "post_done_start");

        for (int i = 0; i < 6; i++) begin
            n     = ($urandom_range(0, 1) == 0) ? 4 : 2;
            w     = 16'($urandom);
            guard = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 20 * n - 1));
            send_word(n, w, 1'b0, guard, $sformatf("rand%0d", i));
            idle_check(int'($urandom_range(1, 5)), $sformatf("rand_gap%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
